// File: rtl/counter_pkg.sv
// -----------------------------------------------------------------------------
// counter_pkg
// Shared constants for the up/down modulus counter family.
//   DEFAULT_WIDTH : default counter width in bits
//   DIR_UP/DIR_DOWN   : encoding of the up_down input
//   MODE_WRAP/MODE_SAT: encoding of the sat_mode input
// -----------------------------------------------------------------------------
package counter_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

endpackage : counter_pkg

// File: rtl/counter_updown_mod_if.sv
// -----------------------------------------------------------------------------
// counter_updown_mod_if
// Control/status bundle of the up/down modulus counter.
//   master : drives enable, up_down, sat_mode, limit, load, load_value,
//            clr_flag; observes result, tc, boundary_hit
//   slave  : the counter itself (mirror directions)
// -----------------------------------------------------------------------------
interface counter_updown_mod_if #(
    parameter int unsigned WIDTH = counter_pkg::DEFAULT_WIDTH
) ();

    logic             enable;
    logic             up_down;
    logic             sat_mode;
    logic [WIDTH-1:0] limit;
    logic             load;
    logic [WIDTH-1:0] load_value;
    logic             clr_flag;
    logic [WIDTH-1:0] result;
    logic             tc;
    logic             boundary_hit;

    modport master (
        output enable,
        output up_down,
        output sat_mode,
        output limit,
        output load,
        output load_value,
        output clr_flag,
        input  result,
        input  tc,
        input  boundary_hit
    );

    modport slave (
        input  enable,
        input  up_down,
        input  sat_mode,
        input  limit,
        input  load,
        input  load_value,
        input  clr_flag,
        output result,
        output tc,
        output boundary_hit
    );

endinterface : counter_updown_mod_if

// File: rtl/counter_next_calc.sv
// -----------------------------------------------------------------------------
// counter_next_calc
// Combinational step of the counter: next count and boundary-event flag.
//   count_i     : current count
//   limit_i     : inclusive upper bound
//   up_down_i   : DIR_UP / DIR_DOWN
//   sat_mode_i  : MODE_SAT / MODE_WRAP
//   next_c_o    : count after one enabled step (combinational)
//   event_c_o   : step hits a boundary (combinational)
// -----------------------------------------------------------------------------
module counter_next_calc
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] count_i,
    input  logic [WIDTH-1:0] limit_i,
    input  logic             up_down_i,
    input  logic             sat_mode_i,
    output logic [WIDTH-1:0] next_c_o,
    output logic             event_c_o
);

    localparam logic [WIDTH-1:0] ZERO = '0;
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

    logic at_top;
    logic at_bottom;

    // A count above a freshly lowered limit is treated as sitting on the top
    // boundary when counting up; counting down ignores the limit entirely.
    assign at_top    = (count_i >= limit_i);
    assign at_bottom = (count_i == ZERO);

    // Step selection; neither path needs more than WIDTH bits since the
    // increment is only taken when count_i < limit_i.
    always_comb begin
        next_c_o  = count_i;
        event_c_o = 1'b0;
        if (up_down_i == DIR_UP) begin
            if (at_top) begin
                event_c_o = 1'b1;
                next_c_o  = (sat_mode_i == MODE_SAT) ? limit_i : ZERO;
            end else begin
                next_c_o  = count_i + ONE;
            end
        end else begin
            if (at_bottom) begin
                event_c_o = 1'b1;
                next_c_o  = (sat_mode_i == MODE_SAT) ? ZERO : limit_i;
            end else begin
                next_c_o  = count_i - ONE;
            end
        end
    end

endmodule : counter_next_calc

// File: rtl/counter_updown_mod.sv
// -----------------------------------------------------------------------------
// counter_updown_mod
// Runtime-programmable up/down modulus counter with wrap/saturate mode,
// parallel load, registered terminal-count pulse and sticky boundary flag.
//   clk   : rising-edge clock
//   reset : synchronous, active-high reset
//   bus   : counter_updown_mod_if.slave (controls in, result/tc/flag out)
// All outputs are registered; priority per edge is reset > load > enable > hold.
// -----------------------------------------------------------------------------
module counter_updown_mod
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH       = DEFAULT_WIDTH,
    parameter int unsigned RESET_VALUE = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    counter_updown_mod_if.slave  bus
);

    localparam logic [WIDTH-1:0] RESET_COUNT = WIDTH'(RESET_VALUE);

    logic [WIDTH-1:0] result_q, result_d;
    logic             tc_q, tc_d;
    logic             flag_q, flag_d;

    logic [WIDTH-1:0] step_next;
    logic             step_event;
    logic [WIDTH-1:0] load_clamped;

    // Next count for an enabled cycle
    counter_next_calc #(
        .WIDTH (WIDTH)
    ) u_next_calc (
        .count_i    (result_q),
        .limit_i    (bus.limit),
        .up_down_i  (bus.up_down),
        .sat_mode_i (bus.sat_mode),
        .next_c_o   (step_next),
        .event_c_o  (step_event)
    );

    // Loaded value never exceeds the current limit
    assign load_clamped = (bus.load_value > bus.limit) ? bus.limit : bus.load_value;

    // Load / enable / hold priority and flag update
    always_comb begin
        result_d = result_q;
        tc_d     = 1'b0;
        flag_d   = flag_q;
        if (bus.load) begin
            result_d = load_clamped;
        end else if (bus.enable) begin
            result_d = step_next;
            tc_d     = step_event;
            // A coinciding event beats clr_flag
            flag_d   = step_event | (flag_q & ~bus.clr_flag);
        end else begin
            flag_d   = flag_q & ~bus.clr_flag;
        end
    end

    // State registers
    always_ff @(posedge clk) begin
        if (reset) begin
            result_q <= RESET_COUNT;
            tc_q     <= 1'b0;
            flag_q   <= 1'b0;
        end else begin
            result_q <= result_d;
            tc_q     <= tc_d;
            flag_q   <= flag_d;
        end
    end

    assign bus.result       = result_q;
    assign bus.tc           = tc_q;
    assign bus.boundary_hit = flag_q;

endmodule : counter_updown_mod

// File: tb/tb_counter_updown_mod.sv
// -----------------------------------------------------------------------------
// tb_counter_updown_mod
// Directed scenarios followed by randomized traffic, every cycle compared
// against a behavioural reference model of the counter.
// -----------------------------------------------------------------------------
module tb_counter_updown_mod;
    import counter_pkg::*;

    localparam int unsigned W  = 8;
    localparam int unsigned RV = 0;

    logic clk;
    logic reset;

    int checks;
    int errors;

    // reference model state
    int m_res;
    int m_tc;
    int m_flag;

    counter_updown_mod_if #(.WIDTH(W)) bus ();

    counter_updown_mod #(
        .WIDTH       (W),
        .RESET_VALUE (RV)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic ld, input logic en,
                         input logic ud, input logic sat, input logic clr,
                         input logic [W-1:0] lim, input logic [W-1:0] lv);
        reset          = rst;
        bus.load       = ld;
        bus.enable     = en;
        bus.up_down    = ud;
        bus.sat_mode   = sat;
        bus.clr_flag   = clr;
        bus.limit      = lim;
        bus.load_value = lv;
    endtask

    // Model of one rising edge, written straight from the behavioural rules
    task automatic model_edge();
        int lim;
        int lv;
        bit ev;
        lim = int'(bus.limit);
        lv  = int'(bus.load_value);
        ev  = 1'b0;
        if (reset) begin
            m_res  = RV;
            m_tc   = 0;
            m_flag = 0;
        end else if (bus.load) begin
            m_res = (lv < lim) ? lv : lim;
            m_tc  = 0;
        end else if (bus.enable) begin
            if (bus.up_down) begin
                if (m_res < lim) m_res = m_res + 1;
                else begin
                    ev    = 1'b1;
                    m_res = bus.sat_mode ? lim : 0;
                end
            end else begin
                if (m_res > 0) m_res = m_res - 1;
                else begin
                    ev    = 1'b1;
                    m_res = bus.sat_mode ? 0 : lim;
                end
            end
            m_tc = ev ? 1 : 0;
            if (ev) m_flag = 1;
            else if (bus.clr_flag) m_flag = 0;
        end else begin
            m_tc = 0;
            if (bus.clr_flag) m_flag = 0;
        end
    endtask

    // One clock: update the model at the edge, compare just after it
    task automatic tick(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        chk({tag, "_result"}, 32'(bus.result), 32'(m_res));
        chk({tag, "_tc"}, 32'(bus.tc), 32'(m_tc));
        chk({tag, "_flag"}, 32'(bus.boundary_hit), 32'(m_flag));
    endtask

    int up_res  [7] = '{1, 2, 3, 4, 5, 0, 1};
    int up_tc   [7] = '{0, 0, 0, 0, 0, 1, 0};
    int up_flag [7] = '{0, 0, 0, 0, 0, 1, 1};
    int sat_res [4] = '{4, 5, 5, 5};
    int sat_tc  [4] = '{0, 0, 1, 1};
    int dn_res  [4] = '{1, 0, 9, 8};
    int dn_tc   [4] = '{0, 0, 1, 0};

    initial begin
        logic [W-1:0] r_lim;
        checks = 0;
        errors = 0;
        m_res  = 0;
        m_tc   = 0;
        m_flag = 0;

        // reset, then wrap up-count with limit 5
        drive(1'b1, 1'b0, 1'b0, DIR_UP, MODE_WRAP, 1'b0, 8'd5, 8'd0);
        tick("reset");
        chk("reset_result", 32'(bus.result), 32'(RV));
        chk("reset_tc", 32'(bus.tc), 32'd0);
        chk("reset_flag", 32'(bus.boundary_hit), 32'd0);
        drive(1'b0, 1'b0, 1'b1, DIR_UP, MODE_WRAP, 1'b0, 8'd5, 8'd0);
        for (int i = 0; i < 7; i++) begin
            tick("up_wrap");
            chk("up_wrap_seq_result", 32'(bus.result), 32'(up_res[i]));
            chk("up_wrap_seq_tc", 32'(bus.tc), 32'(up_tc[i]));
            chk("up_wrap_seq_flag", 32'(bus.boundary_hit), 32'(up_flag[i]));
        end

        // saturate at limit 5 starting from 3
        drive(1'b0, 1'b1, 1'b0, DIR_UP, MODE_SAT, 1'b0, 8'd5, 8'd3);
        tick("sat_load");
        chk("sat_load_result", 32'(bus.result), 32'd3);
        drive(1'b0, 1'b0, 1'b1, DIR_UP, MODE_SAT, 1'b0, 8'd5, 8'd0);
        for (int i = 0; i < 4; i++) begin
            tick("sat_up");
            chk("sat_seq_result", 32'(bus.result), 32'(sat_res[i]));
            chk("sat_seq_tc", 32'(bus.tc), 32'(sat_tc[i]));
        end

        // down wrap from 2 with limit 9
        drive(1'b0, 1'b1, 1'b0, DIR_DOWN, MODE_WRAP, 1'b0, 8'd9, 8'd2);
        tick("dn_load");
        chk("dn_load_result", 32'(bus.result), 32'd2);
        drive(1'b0, 1'b0, 1'b1, DIR_DOWN, MODE_WRAP, 1'b0, 8'd9, 8'd0);
        for (int i = 0; i < 4; i++) begin
            tick("dn_wrap");
            chk("dn_seq_result", 32'(bus.result), 32'(dn_res[i]));
            chk("dn_seq_tc", 32'(bus.tc), 32'(dn_tc[i]));
        end

        // load clamp, load beats enable, reset beats load
        drive(1'b0, 1'b1, 1'b0, DIR_UP, MODE_WRAP, 1'b0, 8'd100, 8'd200);
        tick("clamp");
        chk("clamp_result", 32'(bus.result), 32'd100);
        drive(1'b0, 1'b1, 1'b1, DIR_UP, MODE_WRAP, 1'b0, 8'd100, 8'd42);
        tick("load_vs_en");
        chk("load_vs_en_result", 32'(bus.result), 32'd42);
        drive(1'b1, 1'b1, 1'b1, DIR_UP, MODE_WRAP, 1'b0, 8'd100, 8'd7);
        tick("rst_vs_load");
        chk("rst_vs_load_result", 32'(bus.result), 32'(RV));
        chk("rst_vs_load_tc", 32'(bus.tc), 32'd0);
        chk("rst_vs_load_flag", 32'(bus.boundary_hit), 32'd0);

        // limit lowered below count: wrap, then saturate
        for (int mode = 0; mode < 2; mode++) begin
            drive(1'b1, 1'b0, 1'b0, DIR_UP, MODE_WRAP, 1'b0, 8'd255, 8'd0);
            tick("lim_rst");
            drive(1'b0, 1'b0, 1'b1, DIR_UP, 1'(mode), 1'b0, 8'd255, 8'd0);
            for (int i = 0; i < 50; i++) tick("lim_up");
            chk("lim_at50", 32'(bus.result), 32'd50);
            drive(1'b0, 1'b0, 1'b1, DIR_UP, 1'(mode), 1'b0, 8'd20, 8'd0);
            tick("lim_drop");
            chk("lim_drop_result", 32'(bus.result), (mode == 0) ? 32'd0 : 32'd20);
            chk("lim_drop_tc", 32'(bus.tc), 32'd1);
        end

        // flag: clear while idle, set wins over clear, clear with no event
        drive(1'b0, 1'b0, 1'b0, DIR_UP, MODE_SAT, 1'b1, 8'd20, 8'd0);
        tick("flag_clr_idle");
        chk("flag_clr_idle", 32'(bus.boundary_hit), 32'd0);
        drive(1'b0, 1'b0, 1'b1, DIR_UP, MODE_SAT, 1'b1, 8'd20, 8'd0);
        tick("flag_set_wins");
        chk("flag_set_wins", 32'(bus.boundary_hit), 32'd1);
        drive(1'b0, 1'b0, 1'b0, DIR_UP, MODE_SAT, 1'b1, 8'd20, 8'd0);
        tick("flag_clr");
        chk("flag_clr", 32'(bus.boundary_hit), 32'd0);

        // limit 0: stays 0, tc every enabled cycle
        drive(1'b0, 1'b0, 1'b1, DIR_UP, MODE_WRAP, 1'b0, 8'd0, 8'd0);
        for (int i = 0; i < 4; i++) begin
            tick("lim0");
            chk("lim0_result", 32'(bus.result), 32'd0);
            chk("lim0_tc", 32'(bus.tc), 32'd1);
        end
        drive(1'b0, 1'b0, 1'b1, DIR_DOWN, MODE_WRAP, 1'b0, 8'd0, 8'd0);
        tick("lim0_dn");
        chk("lim0_dn_tc", 32'(bus.tc), 32'd1);

        // enable low holds and drops tc
        drive(1'b0, 1'b1, 1'b0, DIR_UP, MODE_WRAP, 1'b0, 8'd30, 8'd17);
        tick("hold_load");
        drive(1'b0, 1'b0, 1'b0, DIR_UP, MODE_WRAP, 1'b0, 8'd30, 8'd0);
        for (int i = 0; i < 3; i++) begin
            tick("hold");
            chk("hold_result", 32'(bus.result), 32'd17);
            chk("hold_tc", 32'(bus.tc), 32'd0);
        end

        // full-range wrap behaves as modulo-256
        drive(1'b0, 1'b1, 1'b0, DIR_UP, MODE_WRAP, 1'b0, 8'd255, 8'd254);
        tick("mod_load");
        drive(1'b0, 1'b0, 1'b1, DIR_UP, MODE_WRAP, 1'b0, 8'd255, 8'd0);
        tick("mod_up");
        tick("mod_up");
        chk("mod_wrap_result", 32'(bus.result), 32'd0);

        // randomized traffic
        r_lim = 8'($urandom_range(0, 255));
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0) begin
                case ($urandom_range(0, 3))
                    0:       r_lim = 8'd0;
                    1:       r_lim = 8'd255;
                    2:       r_lim = 8'($urandom_range(1, 8));
                    default: r_lim = 8'($urandom_range(0, 255));
                endcase
            end
            drive(1'($urandom_range(0, 99) == 0),
                  1'($urandom_range(0, 9) == 0),
                  1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 7) == 0),
                  r_lim,
                  8'($urandom_range(0, 255)));
            tick("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_counter_updown_mod
